load_unit: RTL and testbench



---
 rtl/load_unit.sv | 167 ++++++++++++++++
 tb/tb_load_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Multi-cycle load path: issues a read to synchronous data memory, waits out its latency, then extends and returns the word/byte.
// Optional store-to-load forwarding is enabled by defining LOAD_UNIT_STORE_FWD_EN.
module load_unit #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_byte,
  input  logic              req_byte_sel,
  input  logic              req_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [15:0]       mem_q,
  input  logic              st_en,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [15:0]       st_data,
  output logic              stall_out,
  output logic              load_valid,
  output logic [15:0]       load_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_reg_q, a_reg_d;
  logic              byte_q, byte_d;
  logic              byte_sel_q, byte_sel_d;
  logic              signed_q, signed_d;
  logic [15:0]       load_data_q, load_data_d;
  logic [15:0]       src_data;
  logic [7:0]        byte_val;
  logic [15:0]       ext_data;

`ifdef LOAD_UNIT_STORE_FWD_EN
  logic              fwd_q, fwd_d;
  logic [15:0]       fwd_data_q, fwd_data_d;
  logic              fwd_hit;
  logic              issue;
  logic [ADDR_W-1:0] snoop_addr;

  // A store in the same cycle as capture is newer than anything latched, so it takes priority.
  always_comb begin
    issue      = (state_q == IDLE) && req_valid;
    snoop_addr = (state_q == IDLE) ? req_addr : a_reg_q;
    fwd_hit    = st_en && (st_addr == snoop_addr) && (issue || (state_q == WAIT));
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    if (issue) begin
      fwd_d = fwd_hit;
    end else if (fwd_hit) begin
      fwd_d = 1'b1;
    end
    if (fwd_hit) begin
      fwd_data_d = st_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign src_data = fwd_hit ? st_data : (fwd_q ? fwd_data_q : mem_q);
`else
  logic unused_st;
  assign unused_st = ^{st_en, st_addr, st_data};
  assign src_data  = mem_q;
`endif

  always_comb begin
    byte_val = byte_sel_q ? src_data[15:8] : src_data[7:0];
    if (!byte_q) begin
      ext_data = src_data;
    end else if (signed_q) begin
      ext_data = {{8{byte_val[7]}}, byte_val};
    end else begin
      ext_data = {8'h00, byte_val};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_reg_d     = a_reg_q;
    byte_d      = byte_q;
    byte_sel_d  = byte_sel_q;
    signed_d    = signed_q;
    load_data_d = load_data_q;
    mem_rden    = 1'b0;
    mem_addr    = a_reg_q;
    stall_out   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_rden   = 1'b1;
          mem_addr   = req_addr;
          stall_out  = 1'b1;
          a_reg_d    = req_addr;
          byte_d     = req_byte;
          byte_sel_d = req_byte_sel;
          signed_d   = req_signed;
          cnt_d      = 3'(MEM_LATENCY);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        stall_out = 1'b1;
        if (cnt_q == 3'd1) begin
          load_data_d = ext_data;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Combinational outputs read as their reset values while reset is held.
    if (reset) begin
      mem_rden  = 1'b0;
      mem_addr  = '0;
      stall_out = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_reg_q     <= '0;
      byte_q      <= 1'b0;
      byte_sel_q  <= 1'b0;
      signed_q    <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_reg_q     <= a_reg_d;
      byte_q      <= byte_d;
      byte_sel_q  <= byte_sel_d;
      signed_q    <= signed_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_valid = (state_q == DONE);
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: three instances at MEM_LATENCY 1, 2, 3 share one memory model and clock.
module tb_load_unit;
  localparam int AW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          req_valid    [3];
  logic [AW-1:0] req_addr     [3];
  logic          req_byte     [3];
  logic          req_byte_sel [3];
  logic          req_signed   [3];
  logic [AW-1:0] mem_addr     [3];
  logic          mem_rden     [3];
  logic [15:0]   mem_q        [3];
  logic          stall_out    [3];
  logic          load_valid   [3];
  logic [15:0]   load_data    [3];
  logic          st_en;
  logic [AW-1:0] st_addr;
  logic [15:0]   st_data;

  logic [15:0]   mem [256];
  int            checks = 0;
  int            errors = 0;
  logic [17:0]   exp_q [$];

  // Memory: preloaded while reset is high; writes land after a same-edge read (read-before-write).
  always @(posedge clock) begin
    if (reset) begin
      mem[1] <= 16'h0011;
      mem[2] <= 16'h0022;
      mem[3] <= 16'h1234;
      mem[4] <= 16'h0001;
      mem[5] <= 16'hBEEF;
      mem[9] <= 16'h80F2;
    end else if (st_en) begin
      mem[st_addr] <= st_data;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_unit
    logic [15:0] pipe_d [4];
    logic [3:0]  pipe_v = '0;
    always @(posedge clock) begin
      pipe_v    <= {pipe_v[2:0], mem_rden[g]};
      pipe_d[0] <= mem[mem_addr[g]];
      for (int k = 1; k < 4; k++) pipe_d[k] <= pipe_d[k-1];
    end
    assign mem_q[g] = pipe_v[g] ? pipe_d[g] : 16'hDEAD;

    load_unit #(.ADDR_W(AW), .MEM_LATENCY(g + 1)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid[g]),
      .req_addr    (req_addr[g]),
      .req_byte    (req_byte[g]),
      .req_byte_sel(req_byte_sel[g]),
      .req_signed  (req_signed[g]),
      .mem_addr    (mem_addr[g]),
      .mem_rden    (mem_rden[g]),
      .mem_q       (mem_q[g]),
      .st_en       (st_en),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .stall_out   (stall_out[g]),
      .load_valid  (load_valid[g]),
      .load_data   (load_data[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every load_valid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    logic [17:0] e;
    for (int u = 0; u < 3; u++) begin
      if (load_valid[u]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load_valid: unit %0d data %0h, expected no pulse", u, load_data[u]);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("load_data_u%0d", u), {14'b0, u[1:0], load_data[u]}, {14'b0, e});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one load on unit u starting this cycle and follow it to completion.
  task automatic run_load(input int u, input logic [7:0] addr, input logic byt, input logic sel,
                          input logic sgn, input logic [15:0] exp, input bit keep,
                          input int st_cyc, input logic [7:0] sa, input logic [15:0] sd);
    int cyc, stall_n, rden_n, done_cyc;
    bit done;
    exp_q.push_back({u[1:0], exp});
    req_valid[u]    = 1'b1;
    req_addr[u]     = addr;
    req_byte[u]     = byt;
    req_byte_sel[u] = sel;
    req_signed[u]   = sgn;
    cyc = 0; stall_n = 0; rden_n = 0; done_cyc = -1; done = 1'b0;
    while (!done && cyc < 20) begin
      st_en   = (cyc == st_cyc);
      st_addr = sa;
      st_data = sd;
      @(negedge clock);
      if (stall_out[u]) stall_n++;
      if (mem_rden[u]) begin
        rden_n++;
        check("rden_cycle", cyc, 0);
        check("mem_addr", {24'b0, mem_addr[u]}, {24'b0, addr});
      end
      if (load_valid[u]) begin
        done     = 1'b1;
        done_cyc = cyc;
        check("stall_in_done", {31'b0, stall_out[u]}, 0);
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    st_en = 1'b0;
    if (!keep) req_valid[u] = 1'b0;
    if (!done) exp_q.delete();
    check("done_cycle", done_cyc, u + 2);
    check("stall_cycles", stall_n, u + 2);
    check("rden_pulses", rden_n, 1);
    check("load_data_hold", {16'b0, load_data[u]}, {16'b0, exp});
  endtask

  initial begin
    int pulses;
    logic [15:0] fwd_exp;
    reset   = 1'b1;
    st_en   = 1'b0;
    st_addr = '0;
    st_data = '0;
    for (int u = 0; u < 3; u++) begin
      req_valid[u] = 1'b1; req_addr[u] = 8'd7;
      req_byte[u] = 1'b0; req_byte_sel[u] = 1'b0; req_signed[u] = 1'b0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      check("reset_stall", {31'b0, stall_out[u]}, 0);
      check("reset_rden", {31'b0, mem_rden[u]}, 0);
      check("reset_mem_addr", {24'b0, mem_addr[u]}, 0);
      check("reset_load_valid", {31'b0, load_valid[u]}, 0);
      check("reset_load_data", {16'b0, load_data[u]}, 0);
    end
    @(posedge clock);
    #1;
    for (int u = 0; u < 3; u++) req_valid[u] = 1'b0;
    reset = 1'b0;
    idle(2);

    run_load(0, 8'd5, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, -1, 8'd0, 16'h0);
    idle(1);
    run_load(0, 8'd9, 1'b1, 1'b1, 1'b1, 16'hFF80, 1'b0, -1, 8'd0, 16'h0);
    run_load(0, 8'd9, 1'b1, 1'b1, 1'b0, 16'h0080, 1'b0, -1, 8'd0, 16'h0);
    run_load(0, 8'd9, 1'b1, 1'b0, 1'b1, 16'hFFF2, 1'b0, -1, 8'd0, 16'h0);
    run_load(0, 8'd9, 1'b1, 1'b0, 1'b0, 16'h00F2, 1'b0, -1, 8'd0, 16'h0);
    run_load(0, 8'd9, 1'b0, 1'b1, 1'b1, 16'h80F2, 1'b0, -1, 8'd0, 16'h0);
    idle(1);
    run_load(2, 8'd3, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, -1, 8'd0, 16'h0);
    run_load(1, 8'd9, 1'b1, 1'b1, 1'b1, 16'hFF80, 1'b0, -1, 8'd0, 16'h0);
    idle(1);

    run_load(0, 8'd1, 1'b0, 1'b0, 1'b0, 16'h0011, 1'b1, -1, 8'd0, 16'h0);
    run_load(0, 8'd2, 1'b0, 1'b0, 1'b0, 16'h0022, 1'b0, -1, 8'd0, 16'h0);
    run_load(2, 8'd1, 1'b0, 1'b0, 1'b0, 16'h0011, 1'b1, -1, 8'd0, 16'h0);
    run_load(2, 8'd2, 1'b0, 1'b0, 1'b0, 16'h0022, 1'b0, -1, 8'd0, 16'h0);
    idle(1);

`ifdef LOAD_UNIT_STORE_FWD_EN
    fwd_exp = 16'hCAFE;
`else
    fwd_exp = 16'h0001;
`endif
    run_load(1, 8'd4, 1'b0, 1'b0, 1'b0, fwd_exp, 1'b0, 1, 8'd4, 16'hCAFE);
    idle(1);

    req_valid[2] = 1'b1; req_addr[2] = 8'd5;
    req_byte[2] = 1'b0; req_byte_sel[2] = 1'b0; req_signed[2] = 1'b0;
    idle(1);
    reset = 1'b1;
    req_valid[2] = 1'b0;
    @(negedge clock);
    check("stall_in_reset", {31'b0, stall_out[2]}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("stall_after_abort", {31'b0, stall_out[2]}, 0);
    check("rden_after_abort", {31'b0, mem_rden[2]}, 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (load_valid[2]) pulses++;
    end
    check("aborted_pulses", pulses, 0);
    @(posedge clock);
    #1;
    run_load(2, 8'd5, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, -1, 8'd0, 16'h0);
    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
